// File: rtl/rbm_visible_layer.sv
// Downward RBM Gibbs half-step: one saturating MAC term per cycle, sigmoid, then LFSR sampling.
// Define RBM_VPROB_OUT_EN to add the VisibleProb output (per-unit sigmoid values).
module rbm_visible_layer #(
    parameter int bitlength = 12,
    parameter int sigmoid_bitlength = 8,
    parameter int visible_dim = 15,
    parameter int hidden_dim = 5,
    parameter logic [bitlength-1:0] Inf = 12'b0111_1111_1111,
    // ROM contents: Weight[v][h] at slice (v*hidden_dim+h), VBias[v] at slice v.
    parameter logic [visible_dim*hidden_dim*bitlength-1:0] weight_init = '0,
    parameter logic [visible_dim*bitlength-1:0] vbias_init = '0,
    parameter logic [sigmoid_bitlength-1:0] seed = 8'hA5,
    parameter logic [sigmoid_bitlength-1:0] lfsr_taps = 8'hB8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   data_valid,
    input  logic [hidden_dim*bitlength-1:0]        HiddenData,
    output logic [visible_dim*bitlength-1:0]       VisibleData,
    output logic                                   busy,
`ifdef RBM_VPROB_OUT_EN
    output logic [visible_dim*sigmoid_bitlength-1:0] VisibleProb,
`endif
    output logic                                   finish
);

    localparam int VW = (visible_dim > 1) ? $clog2(visible_dim) : 1;
    localparam int HW = (hidden_dim > 1) ? $clog2(hidden_dim) : 1;

    typedef enum logic [2:0] {IDLE, BIAS, ACCUM, SAMPLE, DONE} state_t;

    state_t                          state_q, state_d;
    logic [VW-1:0]                   v_q, v_d;
    logic [HW-1:0]                   h_q, h_d;
    logic signed [bitlength-1:0]     acc_q, acc_d;
    logic [sigmoid_bitlength-1:0]    lfsr_q, lfsr_d;
    logic [hidden_dim-1:0]           hreg_q, hreg_d;
    logic [visible_dim*bitlength-1:0] vdata_q, vdata_d;
    logic                            busy_q, busy_d;
    logic                            finish_q, finish_d;
    logic                            armed_q;
`ifdef RBM_VPROB_OUT_EN
    logic [visible_dim*sigmoid_bitlength-1:0] vprob_q, vprob_d;
`endif

    logic signed [bitlength-1:0]     weight_term, vbias_term, acc_sat;
    logic signed [bitlength:0]       sum_wide;
    logic [sigmoid_bitlength-1:0]    prob;
    logic [hidden_dim-1:0]           hidden_on;

    // Piecewise-linear sigmoid: midscale + acc/4, clamped to the output range.
    function automatic logic [sigmoid_bitlength-1:0] sigmoid(input logic signed [bitlength-1:0] a);
        int t;
        t = int'(a >>> 2) + (1 << (sigmoid_bitlength - 1));
        if (t < 0) return '0;
        if (t > (1 << sigmoid_bitlength) - 1) return '1;
        return sigmoid_bitlength'(t);
    endfunction

    function automatic logic [sigmoid_bitlength-1:0] lfsr_next(input logic [sigmoid_bitlength-1:0] s);
        return s[0] ? ((s >> 1) ^ lfsr_taps) : (s >> 1);
    endfunction

    always_comb begin
        hidden_on = '0;
        for (int h = 0; h < hidden_dim; h++) hidden_on[h] = |HiddenData[h*bitlength +: bitlength];
    end

    assign weight_term = hreg_q[h_q] ? weight_init[(int'(v_q)*hidden_dim + int'(h_q))*bitlength +: bitlength] : '0;
    assign vbias_term  = vbias_init[int'(v_q)*bitlength +: bitlength];
    assign sum_wide    = {acc_q[bitlength-1], acc_q} + {weight_term[bitlength-1], weight_term};
    assign prob        = sigmoid(acc_q);

    always_comb begin
        if (sum_wide > $signed({1'b0, Inf}))       acc_sat = Inf;
        else if (sum_wide < -$signed({1'b0, Inf})) acc_sat = -Inf;
        else                                       acc_sat = sum_wide[bitlength-1:0];
    end

    // NOTE: every _d takes its current value first, so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        h_d      = h_q;
        acc_d    = acc_q;
        lfsr_d   = lfsr_q;
        hreg_d   = hreg_q;
        vdata_d  = vdata_q;
        busy_d   = busy_q;
        finish_d = finish_q;
`ifdef RBM_VPROB_OUT_EN
        vprob_d  = vprob_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (data_valid && armed_q) begin
                    hreg_d   = hidden_on;
                    finish_d = 1'b0;
                    busy_d   = 1'b1;
                    v_d      = '0;
                    state_d  = BIAS;
                end
            end
            BIAS: begin
                acc_d   = vbias_term;
                h_d     = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_sat;
                h_d   = h_q + 1'b1;
                if (h_q == HW'(hidden_dim - 1)) state_d = SAMPLE;
            end
            SAMPLE: begin
                vdata_d[int'(v_q)*bitlength +: bitlength] = bitlength'(prob > lfsr_q);
`ifdef RBM_VPROB_OUT_EN
                vprob_d[int'(v_q)*sigmoid_bitlength +: sigmoid_bitlength] = prob;
`endif
                lfsr_d = lfsr_next(lfsr_q);
                if (v_q == VW'(visible_dim - 1)) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = BIAS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only, so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            v_q      <= '0;
            h_q      <= '0;
            acc_q    <= '0;
            lfsr_q   <= seed;
            hreg_q   <= '0;
            vdata_q  <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            armed_q  <= 1'b0;
`ifdef RBM_VPROB_OUT_EN
            vprob_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            h_q      <= h_d;
            acc_q    <= acc_d;
            lfsr_q   <= lfsr_d;
            hreg_q   <= hreg_d;
            vdata_q  <= vdata_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            armed_q  <= 1'b1;  // blocks capture on the first edge after reset release
`ifdef RBM_VPROB_OUT_EN
            vprob_q  <= vprob_d;
`endif
        end
    end

    assign VisibleData = vdata_q;
    assign busy        = busy_q;
    assign finish      = finish_q;
`ifdef RBM_VPROB_OUT_EN
    assign VisibleProb = vprob_q;
`endif

endmodule

// File: tb/tb_rbm_visible_layer.sv
// Bench for rbm_visible_layer: four instances (negative/positive saturation, masking, mixed weights)
// run in lockstep and are compared against a behavioural model of the accumulate/sigmoid/sample rules.
module tb_rbm_visible_layer;

    localparam int VD = 4, HD = 3, BL = 12, SB = 8, NI = 4;
    localparam int LAT = VD * (HD + 2);
    localparam int SEED = 'hA5;

    // Instance 0: negative saturation, 1: positive saturation, 2: masking, 3: mixed weights.
    localparam logic [VD*HD*BL-1:0] W_NEG  = {(VD*HD){12'hA24}};          // -1500
    localparam logic [VD*BL-1:0]    B_NEG  = {VD{12'h801}};               // -2047
    localparam logic [VD*HD*BL-1:0] W_POS  = {(VD*HD){12'h5DC}};          // +1500
    localparam logic [VD*BL-1:0]    B_POS  = {VD{12'h5DC}};
    localparam logic [VD*HD*BL-1:0] W_MASK = {VD{12'h000, 12'h7D0, 12'h000}}; // W[v][1] = 2000
    localparam logic [VD*BL-1:0]    B_MASK = '0;
    localparam logic [VD*HD*BL-1:0] W_MIX  = {12'h3E8, 12'h800, 12'h7FF,   // v3: 2047 -2048 1000
                                              12'hD44, 12'h12C, 12'h12C,   // v2: 300 300 -700
                                              12'hF9C, 12'h384, 12'h8F8,   // v1: -1800 900 -100
                                              12'h0C8, 12'hC18, 12'h5DC};  // v0: 1500 -1000 200
    localparam logic [VD*BL-1:0]    B_MIX  = {12'h830, 12'h000, 12'hE0C, 12'h3E8}; // -2000 0 -500 1000

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic data_valid = 1'b0;
    logic [HD*BL-1:0] HiddenData = '0;
    logic [VD*BL-1:0] vd [NI];
    logic busy [NI];
    logic fin [NI];
`ifdef RBM_VPROB_OUT_EN
    logic [VD*SB-1:0] vp [NI];
`endif

    int n_vec = 0;
    int n_bad = 0;
    int lfsr_m = SEED;
    bit done_seen = 0;

    always #5 clock = ~clock;

    rbm_visible_layer #(.bitlength(BL), .sigmoid_bitlength(SB), .visible_dim(VD), .hidden_dim(HD),
                        .weight_init(W_NEG), .vbias_init(B_NEG)) u_neg (
        .clock(clock), .reset(reset), .data_valid(data_valid), .HiddenData(HiddenData),
        .VisibleData(vd[0]), .busy(busy[0]),
`ifdef RBM_VPROB_OUT_EN
        .VisibleProb(vp[0]),
`endif
        .finish(fin[0]));

    rbm_visible_layer #(.bitlength(BL), .sigmoid_bitlength(SB), .visible_dim(VD), .hidden_dim(HD),
                        .weight_init(W_POS), .vbias_init(B_POS)) u_pos (
        .clock(clock), .reset(reset), .data_valid(data_valid), .HiddenData(HiddenData),
        .VisibleData(vd[1]), .busy(busy[1]),
`ifdef RBM_VPROB_OUT_EN
        .VisibleProb(vp[1]),
`endif
        .finish(fin[1]));

    rbm_visible_layer #(.bitlength(BL), .sigmoid_bitlength(SB), .visible_dim(VD), .hidden_dim(HD),
                        .weight_init(W_MASK), .vbias_init(B_MASK)) u_mask (
        .clock(clock), .reset(reset), .data_valid(data_valid), .HiddenData(HiddenData),
        .VisibleData(vd[2]), .busy(busy[2]),
`ifdef RBM_VPROB_OUT_EN
        .VisibleProb(vp[2]),
`endif
        .finish(fin[2]));

    rbm_visible_layer #(.bitlength(BL), .sigmoid_bitlength(SB), .visible_dim(VD), .hidden_dim(HD),
                        .weight_init(W_MIX), .vbias_init(B_MIX)) u_mix (
        .clock(clock), .reset(reset), .data_valid(data_valid), .HiddenData(HiddenData),
        .VisibleData(vd[3]), .busy(busy[3]),
`ifdef RBM_VPROB_OUT_EN
        .VisibleProb(vp[3]),
`endif
        .finish(fin[3]));

    typedef struct {
        logic [HD-1:0] hid;
        int            acc [VD];   // hand-derived accumulator of the mixed instance
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic int weight(int i, int v, int h);
        logic [VD*HD*BL-1:0] w;
        case (i)
            0: w = W_NEG;
            1: w = W_POS;
            2: w = W_MASK;
            default: w = W_MIX;
        endcase
        return int'($signed(w[(v*HD+h)*BL +: BL]));
    endfunction

    function automatic int vbias(int i, int v);
        logic [VD*BL-1:0] b;
        case (i)
            0: b = B_NEG;
            1: b = B_POS;
            2: b = B_MASK;
            default: b = B_MIX;
        endcase
        return int'($signed(b[v*BL +: BL]));
    endfunction

    // Bias plus every active weight, clipped to +/-2047 after each add.
    function automatic int model_acc(int i, int v, logic [HD-1:0] hid);
        int a;
        a = vbias(i, v);
        for (int h = 0; h < HD; h++) begin
            if (hid[h]) a = a + weight(i, v, h);
            if (a > 2047) a = 2047;
            if (a < -2047) a = -2047;
        end
        return a;
    endfunction

    function automatic int model_sig(int a);
        real r;
        r = $floor(128.0 + a / 4.0);
        if (r < 0.0) return 0;
        if (r > 255.0) return 255;
        return int'(r);
    endfunction

    // Galois LFSR for x^8+x^6+x^5+x^4+1, shifting toward bit 0.
    function automatic int lfsr_step(int s);
        int out_bit;
        out_bit = s & 1;
        s = s >> 1;
        if (out_bit != 0) s = s ^ 'hB8;
        return s;
    endfunction

    function automatic int dut_acc(int i);
        case (i)
            0: return int'(u_neg.acc_q);
            1: return int'(u_pos.acc_q);
            2: return int'(u_mask.acc_q);
            default: return int'(u_mix.acc_q);
        endcase
    endfunction

    function automatic logic [HD*BL-1:0] pack_hidden(logic [HD-1:0] hid);
        logic [HD*BL-1:0] d;
        d = '0;
        for (int h = 0; h < HD; h++)
            if (hid[h]) d[h*BL +: BL] = BL'($urandom_range(1, 4095));
        return d;
    endfunction

    task automatic run_vector(input logic [HD-1:0] hid, input int ti, input bit inject);
        int macc [NI][VD];
        logic [VD*BL-1:0] evd [NI];
        logic [VD*SB-1:0] evp [NI];
        int s;
        for (int i = 0; i < NI; i++) begin
            evd[i] = '0;
            evp[i] = '0;
        end
        for (int v = 0; v < VD; v++) begin
            for (int i = 0; i < NI; i++) begin
                macc[i][v] = model_acc(i, v, hid);
                s = model_sig(macc[i][v]);
                evp[i][v*SB +: SB] = SB'(s);
                evd[i][v*BL +: BL] = BL'(s > lfsr_m);
            end
            lfsr_m = lfsr_step(lfsr_m);
        end

        repeat ($urandom_range(0, 2)) begin
            @(negedge clock);
            if (done_seen) check("finish_held", 64'(fin[3]), 64'd1);
        end
        @(negedge clock);
        data_valid = 1'b1;
        HiddenData = pack_hidden(hid);
        @(negedge clock);
        data_valid = 1'b0;
        HiddenData = BL'($urandom) * HD;
        check("busy_after_accept", 64'(busy[3]), 64'd1);
        check("finish_cleared", 64'(fin[3]), 64'd0);

        for (int k = 1; k <= LAT; k++) begin
            @(negedge clock);
            if (inject && k == 6) begin
                data_valid = 1'b1;
                HiddenData = pack_hidden(~hid);
            end
            if (inject && k == 7) data_valid = 1'b0;
            if (k >= 4 && (k - 4) % 5 == 0) begin
                for (int i = 0; i < NI; i++)
                    check($sformatf("acc_u%0d_v%0d", i, (k - 4) / 5), 64'(dut_acc(i)),
                          (ti >= 0 && i == 3) ? 64'(tbl[ti].acc[(k - 4) / 5]) : 64'(macc[i][(k - 4) / 5]));
            end
            if (k == LAT - 1) begin
                check("busy_before_done", 64'(busy[3]), 64'd1);
                check("finish_before_done", 64'(fin[3]), 64'd0);
            end
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("finish_u%0d", i), 64'(fin[i]), 64'd1);
            check($sformatf("busy_done_u%0d", i), 64'(busy[i]), 64'd0);
            check($sformatf("visible_u%0d", i), 64'(vd[i]), 64'(evd[i]));
`ifdef RBM_VPROB_OUT_EN
            check($sformatf("prob_u%0d", i), 64'(vp[i]), 64'(evp[i]));
`endif
        end
        done_seen = 1;
    endtask

    initial begin
        tbl[0].hid = 3'b000; tbl[0].acc = '{1000, -500, 0, -2000};
        tbl[1].hid = 3'b111; tbl[1].acc = '{1247, -1247, -100, -1001};
        tbl[2].hid = 3'b010; tbl[2].acc = '{0, 400, 300, -2047};
        tbl[3].hid = 3'b101; tbl[3].acc = '{2047, -2047, -400, 1047};

        // Held in reset with data_valid high: outputs stay cleared.
        data_valid = 1'b1;
        HiddenData = pack_hidden(3'b111);
        repeat (3) begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) check($sformatf("rst_visible_u%0d", i), 64'(vd[i]), 64'd0);
            check("rst_busy", 64'(busy[3]), 64'd0);
            check("rst_finish", 64'(fin[3]), 64'd0);
        end
        // Release with data_valid still high: the first edge must not capture.
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < NI; i++) check($sformatf("no_capture_u%0d", i), 64'(busy[i]), 64'd0);
        data_valid = 1'b0;

        // Table vectors (entry 0 doubles as the latency run with HiddenData=0).
        for (int t = 0; t < 4; t++) run_vector(tbl[t].hid, t, 1'b0);

        // A second data_valid mid-run must be ignored.
        run_vector(tbl[1].hid, 1, 1'b1);

        repeat (10) run_vector(3'($urandom_range(0, 7)), -1, 1'b0);

        // Reset in the middle of a vector clears everything at once.
        @(negedge clock);
        data_valid = 1'b1;
        HiddenData = pack_hidden(3'b101);
        @(negedge clock);
        data_valid = 1'b0;
        repeat (12) @(negedge clock);
        reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midrst_visible_u%0d", i), 64'(vd[i]), 64'd0);
            check($sformatf("midrst_busy_u%0d", i), 64'(busy[i]), 64'd0);
        end
        check("midrst_finish", 64'(fin[3]), 64'd0);
        check("midrst_acc", 64'(dut_acc(3)), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        lfsr_m = SEED;
        done_seen = 0;
        run_vector(tbl[2].hid, 2, 1'b0);
        run_vector(tbl[3].hid, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rbm_visible_layer.md
Name: rbm_visible_layer

Overview:
- Downward (hidden→visible) half of the RBM Gibbs step; mirrors the upward hidden layer.
- Takes a sampled hidden vector and computes, per visible unit v, acc = VBias[v] + Σ_h Weight[v][h]·hidden[h], using saturating adds.
- Passes acc through the existing sigmoid unit and samples against an LFSR stream to produce a binary visible reconstruction.
- Time-multiplexed: one MAC datapath, one weight term per cycle.

Parameters:
- bitlength, 12, width of weights, bias, accumulator and each packed data entry
- sigmoid_bitlength, 8, width of sigmoid output and random numbers
- visible_dim, 15, number of visible units produced
- hidden_dim, 5, number of hidden units consumed
- Inf, 12'b0111_1111_1111, saturation magnitude; accumulator is clipped to [-Inf, +Inf]
- weight_path, "../build/data/Hweight15x5.txt", the same visible_dim×hidden_dim matrix the hidden layer uses, indexed Weight[v][h]
- vbias_path, "../build/data/Vbias1x15.txt", visible biases
- seed, 8'hA5, LFSR seed; must be nonzero

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- data_valid  input  1  pulse; HiddenData is valid this cycle
- HiddenData  input  hidden_dim*bitlength  packed hidden vector; entry h is nonzero means unit h is on
- VisibleData  output  visible_dim*bitlength  packed result; each entry is 0 or 1
- busy  output  1  high while a vector is being processed
- finish  output  1  high in DONE; held until the next accepted vector

Behaviour:
- Reset (reset=0, async): state=IDLE, VisibleData=0, busy=0, finish=0, cursor v=0, term index h=0, acc=0, LFSR=seed.
- States: IDLE, BIAS, ACCUM, SAMPLE, DONE.
- IDLE/DONE:
  - data_valid=1 captures HiddenData into an internal register, clears finish, sets busy, sets v=0, and moves to BIAS.
  - data_valid in any other state is ignored; the input is not re-sampled.
- BIAS (1 cycle): acc ← VBias[v]; h ← 0; go to ACCUM.
- ACCUM (exactly hidden_dim cycles):
  - acc ← sat(acc + (hreg[h] ? Weight[v][h] : 0)); h ← h+1.
  - After h = hidden_dim-1, go to SAMPLE.
  - There is no skipping of zero terms; latency is fixed.
- Saturation: compute the sum in bitlength+1 bits. Result > Inf → Inf; result < -Inf → -Inf. Saturation is applied after every add, not only at the end.
- SAMPLE (1 cycle):
  - VisibleData entry v ← {0…,1} if sigmoid(acc) > LFSR, else 0 (strict greater-than).
  - The LFSR advances one step in SAMPLE only.
  - If v = visible_dim-1: go to DONE, finish=1, busy=0. Otherwise v ← v+1 and go to BIAS.
- Latency: finish rises at the clock edge visible_dim*(hidden_dim+2) cycles after the edge that accepted data_valid. With the defaults that is 105.
- VisibleData entries update one by one as they are sampled. Entries not yet reached keep their previous value. VisibleData is only coherent while finish=1.
- LFSR: Galois, sigmoid_bitlength bits, maximal-length taps (8-bit: x^8+x^6+x^5+x^4+1). It never reaches 0. It is not reset on new vectors, only on reset.
- Reset mid-operation returns everything to reset values immediately; no partial result survives.
- data_valid coincident with reset deassertion is ignored; the first capture can happen on the following edge.

Optional Feature:
- Macro: RBM_VPROB_OUT_EN.
- When defined:
  - Extra output port VisibleProb, visible_dim*sigmoid_bitlength wide, reset to 0.
  - Entry v is written with sigmoid(acc) in the same SAMPLE cycle as VisibleData[v], for mean-field reconstruction.
- When undefined: the port and its registers are absent, and all other behaviour is identical.

Test Plan (visible_dim=4, hidden_dim=3, bitlength=12):
- Reset value: hold reset=0 for 3 cycles, applying clock and data_valid=1 → VisibleData=0, busy=0, finish=0 throughout; no capture.
- Latency: release reset, pulse data_valid with HiddenData=0 → busy=1 the next cycle; finish=1 exactly 4*(3+2)=20 edges after capture; busy=0 at the same edge.
- Negative saturation: VBias all 12'h801 (-2047), hidden all 1, Weight all -1500 → each acc clips to -2047, sigmoid=0, VisibleData=0 for every entry; with RBM_VPROB_OUT_EN, VisibleProb all 0.
- Positive saturation: VBias=1500, Weight all 1500, hidden=3'b111 → acc=2047 every unit; VisibleProb = sigmoid(2047) for all entries; VisibleData[v] = 1 iff sigmoid(2047) > the LFSR value in that SAMPLE, checked against a model LFSR from seed 8'hA5.
- Masking: Weight[v][1]=+2000, others 0, VBias=0; hidden=3'b010 vs 3'b000 → acc=2000 vs acc=0 (probe acc, or check VisibleProb = sigmoid(2000) vs sigmoid(0)).
- Busy/reset: a second data_valid at cycle 7 with different HiddenData is ignored, and the result equals a single-vector run. Reset=0 at cycle 12 clears all outputs; a new vector afterwards completes in 20 cycles.
